// File: rtl/icache_pkg.sv
// Shared widths, FSM encodings and I/O region decode for the instruction cache.
// Pure definitions: no latency, no flow control of its own.
package icache_pkg;

    localparam int INDEX_BITS_DEF = 7;
    localparam int ADDR_BITS_DEF  = 17;

    localparam int BYTE_BUS      = 8;
    localparam int INST_BUS      = 32;
    localparam int INST_ADDR_BUS = 32;

    localparam logic [1:0] IO_REGION = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef logic [BYTE_BUS-1:0]      byte_t;
    typedef logic [INST_BUS-1:0]      inst_t;
    typedef logic [INST_ADDR_BUS-1:0] inst_addr_t;

    // Address bits [17:16] select the memory-mapped I/O window, which must never be cached.
    function automatic logic is_io(input logic [1:0] region);
        return region == IO_REGION;
    endfunction

endpackage

// File: rtl/icache_if.sv
// IF-stage fetch port plus memctrl byte port of the instruction cache.
// Wires only; rdy freezes the cache, mem_r_i paces the fill.
interface icache_if;
    import icache_pkg::*;

    logic       rdy;
    logic       flush;
    logic       req_i;
    inst_addr_t pc_i;
    logic       inst_valid_o;
    inst_t      inst_o;
    logic       mem_req_o;
    inst_addr_t mem_addr_o;
    logic       mem_r_i;
    byte_t      mem_data_i;

    modport slave (
        input  rdy, flush, req_i, pc_i, mem_r_i, mem_data_i,
        output inst_valid_o, inst_o, mem_req_o, mem_addr_o
    );

    modport master (
        output rdy, flush, req_i, pc_i, mem_r_i, mem_data_i,
        input  inst_valid_o, inst_o, mem_req_o, mem_addr_o
    );

endinterface

// File: rtl/icache_array.sv
// Direct-mapped tag/data store with a valid vector; combinational read, synchronous write.
// Writes are dropped while rdy is low; only reset clears valid bits.
module icache_array
    import icache_pkg::*;
#(
    parameter int IDX_W = INDEX_BITS_DEF,
    parameter int TAG_W = ADDR_BITS_DEF - INDEX_BITS_DEF - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_vld,
    output logic [TAG_W-1:0] rd_tag,
    output inst_t            rd_dat,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  inst_t            wr_dat
);
    localparam int LINES = 2 ** IDX_W;

    logic [LINES-1:0]          valid_q, valid_d;
    logic [TAG_W+INST_BUS-1:0] line_q [LINES];

    assign rd_vld = valid_q[rd_idx];
    assign {rd_tag, rd_dat} = line_q[rd_idx];

    always_comb begin
        valid_d = valid_q;
        if (rdy && we) valid_d[wr_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid_q <= '0;
        else      valid_q <= valid_d;
    end

    // Storage itself is not reset; the valid vector masks stale contents.
    always_ff @(posedge clk) begin
        if (rdy && we) line_q[wr_idx] <= {wr_tag, wr_dat};
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped I-cache: hit answers next cycle, miss fills 4 bytes then answers 1 cycle later.
// rdy=0 freezes all state; memctrl may hold off mem_r_i indefinitely; flush aborts any fetch.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
    input  logic clk,
    input  logic rst,
    icache_if.slave bus
);
    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  count_q, count_d;
    logic [23:0] shift_q, shift_d;
    inst_addr_t  addr_q, addr_d;
    inst_t       inst_q, inst_d;
    logic        inst_valid_q, inst_valid_d;
    logic        mem_req_q, mem_req_d;

    logic [INDEX_BITS-1:0] rd_idx, wr_idx;
    logic [TAG_BITS-1:0]   rd_tag, pc_tag, wr_tag;
    inst_t                 rd_dat, wr_dat;
    logic                  rd_vld, hit, we;

    assign rd_idx = bus.pc_i[INDEX_BITS+1:2];
    assign pc_tag = bus.pc_i[ADDR_BITS-1:INDEX_BITS+2];
    assign hit    = rd_vld && (rd_tag == pc_tag);

    // The fill writes back using the captured word address, not the live pc.
    assign wr_idx = addr_q[INDEX_BITS+1:2];
    assign wr_tag = addr_q[ADDR_BITS-1:INDEX_BITS+2];
    assign wr_dat = {bus.mem_data_i, shift_q};

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        shift_d      = shift_q;
        addr_d       = addr_q;
        inst_d       = inst_q;
        inst_valid_d = 1'b0;
        mem_req_d    = mem_req_q;
        we           = 1'b0;

        if (bus.flush) begin
            state_d   = S_IDLE;
            count_d   = 2'd0;
            mem_req_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // While the previous answer is on the bus, the held request is that same fetch.
                    if (bus.req_i && !inst_valid_q) begin
                        if (hit) begin
                            inst_valid_d = 1'b1;
                            inst_d       = rd_dat;
                        end else begin
                            state_d   = S_FILL;
                            count_d   = 2'd0;
                            mem_req_d = 1'b1;
                            addr_d    = bus.pc_i & ~32'h3;
                        end
                    end
                end
                S_FILL: begin
                    if (bus.mem_r_i) begin
                        shift_d = {bus.mem_data_i, shift_q[23:8]};
                        count_d = count_q + 2'd1;
                        addr_d  = {addr_q[31:2], count_q + 2'd1};
                        if (count_q == 2'd3) begin
                            state_d      = S_RESP;
                            mem_req_d    = 1'b0;
                            inst_valid_d = 1'b1;
                            inst_d       = wr_dat;
                            we           = !is_io(addr_q[17:16]);
                        end
                    end
                end
                S_RESP:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            count_q      <= 2'd0;
            shift_q      <= '0;
            addr_q       <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            mem_req_q    <= 1'b0;
        end else if (bus.rdy) begin
            state_q      <= state_d;
            count_q      <= count_d;
            shift_q      <= shift_d;
            addr_q       <= addr_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            mem_req_q    <= mem_req_d;
        end
    end

    icache_array #(
        .IDX_W (INDEX_BITS),
        .TAG_W (TAG_BITS)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .rdy    (bus.rdy),
        .rd_idx (rd_idx),
        .rd_vld (rd_vld),
        .rd_tag (rd_tag),
        .rd_dat (rd_dat),
        .we     (we),
        .wr_idx (wr_idx),
        .wr_tag (wr_tag),
        .wr_dat (wr_dat)
    );

    assign bus.inst_valid_o = inst_valid_q;
    assign bus.inst_o       = inst_q;
    assign bus.mem_req_o    = mem_req_q;
    assign bus.mem_addr_o   = addr_q;

endmodule
